counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Sequencer for a programmable modulo counter. Software or an upstream FSM loads a modulus and a wrap count, issues `start`, and the block runs the counter through the requested number of full cycles, with pause and stop. It reports each wrap and completion, and rejects illegal configurations. It sits between the control logic and the modulo-count datapath, replacing hard-wired `MOD` constants with a run-time-configured, sequenced counter.

## Interface
- `WIDTH`, 3: counter width; legal modulus range 2..2^WIDTH-1.
- `RUNS_W`, 4: width of the wrap-count field.

- `clk`, in, 1: clock; all state changes on rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cfg_mod`, in, WIDTH: modulus; sampled only on an accepted `start`.
- `cfg_runs`, in, RUNS_W: number of full count cycles; sampled only on an accepted `start`.
- `start`, in, 1: level, sampled each edge; acted on only in IDLE.
- `stop`, in, 1: abort the run; highest priority.
- `pause`, in, 1: freeze the count while high.
- `count`, out, WIDTH: current count value.
- `runs_left`, out, RUNS_W: wraps remaining, including the current one.
- `busy`, out, 1: high in RUN or HOLD.
- `held`, out, 1: high in HOLD.
- `wrap`, out, 1: one-cycle pulse on each `mod_q-1` -> 0 transition.
- `done`, out, 1: one-cycle pulse on the final wrap.
- `err`, out, 1: one-cycle pulse when a `start` carries an illegal configuration.

## Operation
- States: IDLE, RUN, HOLD. Reset -> IDLE with `count`=0, `runs_left`=0, `busy`=0, `held`=0, `wrap`=0, `done`=0, `err`=0.
- Internal registers `mod_q` and `runs_q` latch `cfg_mod` and `cfg_runs` on an accepted start. The cfg inputs are don't-care at all other times.
- Start validation is applied only in IDLE with `start`=1:
  - If `cfg_mod`<2 or `cfg_runs`=0: pulse `err`, stay in IDLE, leave `count` unchanged.
  - Otherwise: latch config, go to RUN, set `count`=0 and `runs_left`=`cfg_runs`.
- `start` in RUN or HOLD is ignored and has no error effect.
- RUN, each edge, in priority order:
  1. `stop`=1 -> IDLE, `count`=0, `runs_left`=0, no `wrap` and no `done`.
  2. `pause`=1 -> HOLD, `count` unchanged.
  3. `count`<`mod_q-1` -> `count`+1.
  4. `count`=`mod_q-1` -> `count`=0 and pulse `wrap`.
     - If `runs_left`>1: decrement `runs_left`.
     - If `runs_left`=1: pulse `done` and apply end-of-run behaviour (see Configuration).
- HOLD, each edge:
  - `stop`=1 -> IDLE, with the same clearing as in RUN.
  - `pause`=0 -> RUN, with no increment on this edge.
  - Otherwise hold every output.
- Arithmetic is unsigned. `count` never exceeds `mod_q-1`, and there is no wrap at 2^WIDTH.
- Reset mid-run aborts immediately and returns to the reset values. No `done` is issued.

## Timing
- Registered outputs only; `wrap`, `done` and `err` are each high for exactly one cycle.
- Accepted start sampled at edge k: `busy`=1 and `count`=0 after k, and `count`=1 after k+1 if not paused.
- Unpaused run length:
  - `done` is visible after edge k + `mod_q`×`runs_q`.
  - Each count value is held for one cycle.
- Pause latency:
  - Pause asserted and sampled at edge p: `count` is frozen from edge p.
  - Pause deasserted and sampled at edge r: the first increment happens at edge r+1.
  - Every pause therefore costs one extra cycle.
- Without autoreload, `busy`=0 in the same cycle as `done`=1. A new `start` is accepted on the next edge.

## Configuration
- `COUNTER_CTRL_AUTORELOAD_EN` defined:
  - On the final wrap, `done` pulses and the state stays RUN.
  - `runs_left` reloads from `runs_q`, `busy` stays 1, and counting continues seamlessly.
  - Only `stop` or `rst` ends operation.
- Not defined:
  - On the final wrap, the state goes to IDLE with `busy`=0, `count`=0 and `runs_left`=0.
  - `wrap` and `done` pulse together.

## Test plan
- Basic run, cfg_mod=5, cfg_runs=2, start at edge 0:
  - `count` follows 0,1,2,3,4,0,1,2,3,4,0.
  - `wrap` pulses after edges 5 and 10.
  - `done` and `busy` fall after edge 10.
- Illegal config, cfg_mod=1 (then cfg_runs=0) with start:
  - `err` pulses for one cycle and `busy` stays 0.
  - Next, cfg_mod=7, cfg_runs=1 with start: `done` after 7 edges, no `err`.
- Pause, cfg_mod=4, cfg_runs=1:
  - Assert pause at count=2 for 3 edges: `held`=1 and `count` stays 2.
  - After release: count goes 3, 0 with `done`; total 4+3+1 edges.
- Stop mid-run, cfg_mod=6, cfg_runs=3:
  - Stop at runs_left=2, count=3: next cycle `count`=0, `busy`=0, no `done`.
  - Stop while in HOLD: same result.
- Async reset mid-run:
  - Assert `rst` between edges: all outputs go to reset values immediately, and `done` never pulses.
  - `start` during `busy` with different cfg: ignored, and the original `mod_q` stays in effect.
- With `COUNTER_CTRL_AUTORELOAD_EN`, cfg_mod=3, cfg_runs=2:
  - `done` after edges 6 and 12, and `busy` stays 1.
  - Stop at edge 14: IDLE.

Source files
------------

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequenced modulo counter with pause, stop, wrap/done reporting and config validation.
// Define COUNTER_CTRL_AUTORELOAD_EN to keep running after the final wrap instead of returning to IDLE.
module counter_ctrl #(
  parameter int WIDTH  = 3,
  parameter int RUNS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cfg_mod,
  input  logic [RUNS_W-1:0] cfg_runs,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [WIDTH-1:0]  count,
  output logic [RUNS_W-1:0] runs_left,
  output logic              busy,
  output logic              held,
  output logic              wrap,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t              state_q;
  logic [WIDTH-1:0]    count_q, mod_q;
  logic [RUNS_W-1:0]   runs_left_q, runs_q;
  logic                wrap_q, done_q, err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mod_q       <= '0;
      runs_left_q <= '0;
      runs_q      <= '0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (cfg_mod < WIDTH'(2) || cfg_runs == '0) err_q <= 1'b1;
          else begin
            mod_q       <= cfg_mod;
            runs_q      <= cfg_runs;
            count_q     <= '0;
            runs_left_q <= cfg_runs;
            state_q     <= RUN;
          end
        end
        RUN: if (stop) begin
          state_q     <= IDLE;
          count_q     <= '0;
          runs_left_q <= '0;
        end else if (pause) state_q <= HOLD;
        else if (count_q != mod_q - 1'b1) count_q <= count_q + 1'b1;
        else begin
          count_q <= '0;
          wrap_q  <= 1'b1;
          if (runs_left_q > RUNS_W'(1)) runs_left_q <= runs_left_q - 1'b1;
          else begin
            done_q <= 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
            runs_left_q <= runs_q;
`else
            runs_left_q <= '0;
            state_q     <= IDLE;
`endif
          end
        end
        HOLD: if (stop) begin
          state_q     <= IDLE;
          count_q     <= '0;
          runs_left_q <= '0;
        end else if (!pause) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign count     = count_q;
  assign runs_left = runs_left_q;
  assign busy      = state_q != IDLE;
  assign held      = state_q == HOLD;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed scenarios plus randomized run checked against a progress-based reference model.
module tb_counter_ctrl;
  logic       clk = 0, rst = 1;
  logic [2:0] cfg_mod = 0;
  logic [3:0] cfg_runs = 0;
  logic       start = 0, stop = 0, pause = 0;
  logic [2:0] count;
  logic [3:0] runs_left;
  logic       busy, held, wrap, done, err;
  int n_checks = 0, n_fail = 0;
  // model: run progress as number of advancing edges since start
  int m_p = 0, m_mod = 0, m_runs = 0;
  bit m_busy = 0, m_held = 0, m_wrap = 0, m_done = 0, m_err = 0;

  counter_ctrl dut (.clk(clk), .rst(rst), .cfg_mod(cfg_mod), .cfg_runs(cfg_runs), .start(start),
    .stop(stop), .pause(pause), .count(count), .runs_left(runs_left), .busy(busy), .held(held),
    .wrap(wrap), .done(done), .err(err));

  always #5 clk = ~clk;

  task automatic model_reset;
    m_p = 0; m_busy = 0; m_held = 0; m_wrap = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step;
    m_wrap = 0; m_done = 0; m_err = 0;
    if (rst) model_reset();
    else if (!m_busy) begin
      if (start) begin
        if (cfg_mod < 2 || cfg_runs == 0) m_err = 1;
        else begin m_busy = 1; m_held = 0; m_p = 0; m_mod = cfg_mod; m_runs = cfg_runs; end
      end
    end else if (stop) begin m_busy = 0; m_held = 0; m_p = 0; end
    else if (m_held) m_held = pause;
    else if (pause) m_held = 1;
    else begin
      m_p++;
      m_wrap = (m_p % m_mod) == 0;
      if (m_p == m_mod * m_runs) begin
        m_done = 1;
        m_p = 0;
`ifndef COUNTER_CTRL_AUTORELOAD_EN
        m_busy = 0;
`endif
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic launch(input int md, input int rn);
    cfg_mod = 3'(md); cfg_runs = 4'(rn); start = 1;
    tick();
    start = 0; cfg_mod = 0; cfg_runs = 0;
  endtask

  task automatic test_reset;
    rst = 1; tick(); tick();
    n_checks++; if ({count, runs_left, busy, held, wrap, done, err} !== 11'd0) begin n_fail++; $display("FAIL reset outputs got=%b exp=0", {count, runs_left, busy, held, wrap, done, err}); end
    rst = 0; tick();
    n_checks++; if (busy !== 0 || count !== 0) begin n_fail++; $display("FAIL reset_release busy=%b count=%0d exp 0/0", busy, count); end
  endtask

  task automatic test_basic;
    launch(5, 2);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) tick();
      n_checks++; if (count !== 3'(i % 5)) begin n_fail++; $display("FAIL basic_count e%0d got=%0d exp=%0d", i, count, i % 5); end
      n_checks++; if (wrap !== (i == 5 || i == 10)) begin n_fail++; $display("FAIL basic_wrap e%0d got=%b", i, wrap); end
      n_checks++; if (done !== (i == 10)) begin n_fail++; $display("FAIL basic_done e%0d got=%b", i, done); end
`ifndef COUNTER_CTRL_AUTORELOAD_EN
      n_checks++; if (busy !== (i < 10)) begin n_fail++; $display("FAIL basic_busy e%0d got=%b exp=%b", i, busy, i < 10); end
`endif
    end
    n_checks++; if (runs_left !== 4'(m_busy ? 2 : 0)) begin n_fail++; $display("FAIL basic_runs_left got=%0d", runs_left); end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_illegal;
    launch(1, 3);
    n_checks++; if (err !== 1 || busy !== 0) begin n_fail++; $display("FAIL illegal_mod err=%b busy=%b exp 1/0", err, busy); end
    tick();
    n_checks++; if (err !== 0) begin n_fail++; $display("FAIL illegal_pulse err=%b exp 0", err); end
    launch(5, 0);
    n_checks++; if (err !== 1 || busy !== 0 || count !== 0) begin n_fail++; $display("FAIL illegal_runs err=%b busy=%b count=%0d", err, busy, count); end
    launch(7, 1);
    n_checks++; if (err !== 0 || busy !== 1) begin n_fail++; $display("FAIL legal_start err=%b busy=%b exp 0/1", err, busy); end
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_checks++; if (done !== (i == 7) || err !== 0) begin n_fail++; $display("FAIL legal_run e%0d done=%b err=%b", i, done, err); end
    end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_pause;
    launch(4, 1);
    tick(); tick();
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (held !== 1 || count !== 2) begin n_fail++; $display("FAIL pause_hold held=%b count=%0d exp 1/2", held, count); end
    end
    pause = 0;
    tick();
    n_checks++; if (held !== 0 || count !== 2) begin n_fail++; $display("FAIL pause_release held=%b count=%0d exp 0/2", held, count); end
    tick();
    n_checks++; if (count !== 3 || done !== 0) begin n_fail++; $display("FAIL pause_resume count=%0d done=%b exp 3/0", count, done); end
    tick();
    n_checks++; if (count !== 0 || done !== 1 || wrap !== 1) begin n_fail++; $display("FAIL pause_done count=%0d done=%b wrap=%b", count, done, wrap); end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_stop;
    launch(6, 3);
    repeat (9) tick();
    n_checks++; if (runs_left !== 2 || count !== 3) begin n_fail++; $display("FAIL stop_pre runs_left=%0d count=%0d exp 2/3", runs_left, count); end
    stop = 1; tick(); stop = 0;
    n_checks++; if (count !== 0 || busy !== 0 || done !== 0 || runs_left !== 0) begin n_fail++; $display("FAIL stop_run count=%0d busy=%b done=%b rl=%0d", count, busy, done, runs_left); end
    launch(6, 3);
    tick(); tick(); pause = 1; tick();
    n_checks++; if (held !== 1) begin n_fail++; $display("FAIL stop_hold_pre held=%b exp 1", held); end
    stop = 1; tick(); stop = 0; pause = 0;
    n_checks++; if (count !== 0 || busy !== 0 || held !== 0 || done !== 0 || runs_left !== 0) begin n_fail++; $display("FAIL stop_hold count=%0d busy=%b held=%b done=%b", count, busy, held, done); end
  endtask

  task automatic test_async_reset;
    launch(5, 1);
    tick(); tick(); tick();
    #2 rst = 1;
    #1;
    model_reset();
    n_checks++; if ({count, runs_left, busy, held, wrap, done, err} !== 11'd0) begin n_fail++; $display("FAIL async_reset got=%b exp=0", {count, runs_left, busy, held, wrap, done, err}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) rst = 0;
      n_checks++; if (done !== 0 || busy !== 0) begin n_fail++; $display("FAIL async_no_done done=%b busy=%b", done, busy); end
    end
  endtask

  task automatic test_ignore_start;
    launch(4, 1);
    cfg_mod = 7; cfg_runs = 5; start = 1;
    tick();
    start = 0;
    n_checks++; if (err !== 0 || count !== 1 || runs_left !== 1) begin n_fail++; $display("FAIL ignore_start err=%b count=%0d rl=%0d exp 0/1/1", err, count, runs_left); end
    tick(); tick(); tick();
    n_checks++; if (done !== 1 || count !== 0) begin n_fail++; $display("FAIL ignore_start_done done=%b count=%0d exp 1/0", done, count); end
    stop = 1; tick(); stop = 0;
  endtask

`ifdef COUNTER_CTRL_AUTORELOAD_EN
  task automatic test_autoreload;
    launch(3, 2);
    for (int i = 1; i <= 14; i++) begin
      tick();
      n_checks++; if (done !== (i == 6 || i == 12) || busy !== 1) begin n_fail++; $display("FAIL autoreload e%0d done=%b busy=%b", i, done, busy); end
    end
    n_checks++; if (runs_left !== 2 || count !== 2) begin n_fail++; $display("FAIL autoreload_state rl=%0d count=%0d exp 2/2", runs_left, count); end
    stop = 1; tick(); stop = 0;
    n_checks++; if (busy !== 0 || count !== 0) begin n_fail++; $display("FAIL autoreload_stop busy=%b count=%0d", busy, count); end
  endtask
`endif

  task automatic test_random;
    int ec, er;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      cfg_mod = 3'($urandom_range(0, 7));
      cfg_runs = 4'($urandom_range(0, 3));
      pause = ($urandom_range(0, 4) == 0);
      stop = ($urandom_range(0, 40) == 0);
      tick();
      ec = m_busy ? m_p % m_mod : 0;
      er = m_busy ? m_runs - m_p / m_mod : 0;
      n_checks++; if (count !== 3'(ec) || runs_left !== 4'(er)) begin n_fail++; $display("FAIL rand_count c%0d count=%0d/%0d runs_left=%0d/%0d", i, count, ec, runs_left, er); end
      n_checks++; if (busy !== m_busy || held !== m_held) begin n_fail++; $display("FAIL rand_state c%0d busy=%b/%b held=%b/%b", i, busy, m_busy, held, m_held); end
      n_checks++; if (wrap !== m_wrap || done !== m_done || err !== m_err) begin n_fail++; $display("FAIL rand_pulse c%0d wrap=%b/%b done=%b/%b err=%b/%b", i, wrap, m_wrap, done, m_done, err, m_err); end
    end
    start = 0; pause = 0; stop = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_pause();
    test_stop();
    test_async_reset();
    test_ignore_start();
`ifdef COUNTER_CTRL_AUTORELOAD_EN
    test_autoreload();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
